// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bubble_pkg
// Description : Shared types and helpers for the bubble field renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    typedef struct packed {
        logic        active;
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] r;
        logic [7:0]  R;
        logic [7:0]  G;
        logic [7:0]  B;
        logic [7:0]  age;
    } bubble_t;

    typedef enum logic [1:0] {
        MODE_FADE   = 2'd0,
        MODE_RISE   = 2'd1,
        MODE_FREEZE = 2'd2,
        MODE_CLEAR  = 2'd3
    } mode_e;

    localparam int c_ramp_frac = 16;

    // Scales the offset inside a screen segment onto 0..255 via a fixed-point multiplier.
    function automatic logic [7:0] hue_ramp(input logic [10:0] offset, input logic [31:0] mult);
        logic [42:0] prod;
        logic [42:0] hi;
        prod = {32'd0, offset} * {11'd0, mult};
        hi   = prod >> c_ramp_frac;
        return (|hi[42:8]) ? 8'hFF : hi[7:0];
    endfunction

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bubble_lfsr
// Description : Galois LFSR, seed 1, advances every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bubble_lfsr #(
    parameter int                LFSR_W   = 34,
    parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(64'h2_0400_0003)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [LFSR_W-1:0] o_rand
);

    logic [LFSR_W-1:0] r_lfsr_q;
    logic [LFSR_W-1:0] w_lfsr_d;

    always_comb begin
        w_lfsr_d = {1'b0, r_lfsr_q[LFSR_W-1:1]} ^ (r_lfsr_q[0] ? TAP_MASK : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr_q <= LFSR_W'(1);
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign o_rand = r_lfsr_q;

endmodule
`default_nettype wire

// File: rtl/bubble_field_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bubble_field_renderer
// Description : Audio-reactive bubble pool with a 2-stage pixel compositor.
// Revision    : 1.0 - initial release
// ============================================================================
module bubble_field_renderer
    import bubble_pkg::*;
#(
    parameter int NUM_BUBBLES = 16,
    parameter int NUM_BANDS   = 16,
    parameter int DATA_W      = 4,
    parameter int MIN_RADIUS  = 45,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SPAWN_LOG2  = 21,
    parameter int DECAY_LOG2  = 19,
    parameter int RISE_LOG2   = 18,
    parameter int LFSR_W      = 34
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_BANDS*DATA_W-1:0]          i_DATA,
    input  logic [10:0]                          i_VGA_X,
    input  logic [10:0]                          i_VGA_Y,
    input  logic [4:0]                           i_radius_off,
    input  logic [1:0]                           i_mode,
    output logic [7:0]                           o_VGA_R,
    output logic [7:0]                           o_VGA_G,
    output logic [7:0]                           o_VGA_B,
    output logic [$clog2(NUM_BUBBLES+1)-1:0]     o_active_cnt
);

    localparam int          c_cnt_w    = $clog2(NUM_BUBBLES + 1);
    localparam int          c_idx_w    = $clog2(NUM_BUBBLES);
    localparam int          c_int_w    = DATA_W + $clog2(NUM_BANDS);
    localparam int          c_bidx_w   = $clog2(NUM_BANDS);
    localparam int          c_seg      = H_RES / 4;
    localparam logic [31:0] c_ramp_mul = 32'((255 << c_ramp_frac) / c_seg);

    mode_e               w_mode;
    logic                w_run;
    logic [31:0]         r_cyc_q, w_cyc_d;
    logic                r_spawn_tick_q, w_spawn_tick_d;
    logic                r_decay_tick_q, w_decay_tick_d;
    logic                r_rise_tick_q, w_rise_tick_d;
    logic [LFSR_W-1:0]   w_rand;
    logic                w_unused_rand;
    logic [DATA_W-1:0]   w_bands [NUM_BANDS];
    logic [c_int_w-1:0]  w_intensity;
    logic [10:0]         w_x_raw, w_y_raw, w_new_x, w_new_y, w_seg_base;
    logic [1:0]          w_seg;
    logic [7:0]          w_ramp;
    logic [c_bidx_w-1:0] w_band_idx;
    bubble_t             w_new_bubble;
    logic                w_free_found, w_spawn;
    logic [c_idx_w-1:0]  w_free_idx, w_old_idx, w_slot;
    logic [7:0]          w_old_age;
    bubble_t             r_pool_q [NUM_BUBBLES];
    bubble_t             w_pool_d [NUM_BUBBLES];
    logic [c_cnt_w-1:0]  r_active_cnt_q, w_active_cnt_d;
    logic [NUM_BUBBLES-1:0] r_hit_q, w_hit_d;
    logic [7:0]          r_sr_q [NUM_BUBBLES], w_sr_d [NUM_BUBBLES];
    logic [7:0]          r_sg_q [NUM_BUBBLES], w_sg_d [NUM_BUBBLES];
    logic [7:0]          r_sb_q [NUM_BUBBLES], w_sb_d [NUM_BUBBLES];
    logic [7:0]          r_out_r_q, r_out_g_q, r_out_b_q;
    logic [7:0]          w_out_r_d, w_out_g_d, w_out_b_d;

    assign w_mode = mode_e'(i_mode);
    assign w_run  = (w_mode == MODE_FADE) || (w_mode == MODE_RISE);

    bubble_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_rand (w_rand)
    );
    assign w_unused_rand = ^w_rand;

    // Ticks fire in the cycle where the low counter bits have just wrapped to zero.
    always_comb begin
        w_cyc_d        = r_cyc_q + 32'd1;
        w_spawn_tick_d = &r_cyc_q[SPAWN_LOG2-1:0];
        w_decay_tick_d = &r_cyc_q[DECAY_LOG2-1:0];
        w_rise_tick_d  = &r_cyc_q[RISE_LOG2-1:0];
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        assign w_bands[b] = i_DATA[b*DATA_W +: DATA_W];
    end

    always_comb begin
        w_intensity = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            w_intensity = w_intensity + c_int_w'(w_bands[b]);
        end
    end

    always_comb begin
        w_x_raw = {1'b0, w_rand[9:0]};
        w_y_raw = {2'b00, w_rand[18:10]};
        w_new_x = (w_x_raw >= 11'(H_RES)) ? w_x_raw - 11'd512 : w_x_raw;
        w_new_y = (w_y_raw >= 11'(V_RES)) ? w_y_raw - 11'd256 : w_y_raw;
        if (w_new_x >= 11'(3*c_seg)) begin
            w_seg = 2'd3; w_seg_base = 11'(3*c_seg);
        end else if (w_new_x >= 11'(2*c_seg)) begin
            w_seg = 2'd2; w_seg_base = 11'(2*c_seg);
        end else if (w_new_x >= 11'(c_seg)) begin
            w_seg = 2'd1; w_seg_base = 11'(c_seg);
        end else begin
            w_seg = 2'd0; w_seg_base = 11'd0;
        end
        w_ramp     = hue_ramp(w_new_x - w_seg_base, c_ramp_mul);
        w_band_idx = c_bidx_w'(w_seg) * c_bidx_w'(NUM_BANDS/4) + c_bidx_w'(1);

        w_new_bubble        = '0;
        w_new_bubble.active = 1'b1;
        w_new_bubble.x      = w_new_x;
        w_new_bubble.y      = w_new_y;
        w_new_bubble.r      = 11'(MIN_RADIUS) + 11'({w_bands[w_band_idx], 2'b00}) + 11'(w_rand[23:19]);
        case (w_seg)
            2'd0:    begin w_new_bubble.R = 8'hFF;          w_new_bubble.G = w_ramp;         w_new_bubble.B = 8'h00;  end
            2'd1:    begin w_new_bubble.R = 8'hFF - w_ramp; w_new_bubble.G = 8'hFF;          w_new_bubble.B = 8'h00;  end
            2'd2:    begin w_new_bubble.R = 8'h00;          w_new_bubble.G = 8'hFF;          w_new_bubble.B = w_ramp; end
            default: begin w_new_bubble.R = 8'h00;          w_new_bubble.G = 8'hFF - w_ramp; w_new_bubble.B = 8'hFF;  end
        endcase
    end

    // Lowest free slot, otherwise the oldest live slot (lowest index on ties).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_idx    = '0;
        w_old_age    = r_pool_q[0].age;
        for (int i = NUM_BUBBLES - 1; i >= 0; i--) begin
            if (!r_pool_q[i].active) begin
                w_free_found = 1'b1;
                w_free_idx   = c_idx_w'(i);
            end
        end
        for (int i = 1; i < NUM_BUBBLES; i++) begin
            if (r_pool_q[i].age > w_old_age) begin
                w_old_age = r_pool_q[i].age;
                w_old_idx = c_idx_w'(i);
            end
        end
        w_slot  = w_free_found ? w_free_idx : w_old_idx;
        w_spawn = r_spawn_tick_q && w_run &&
                  (16'(w_intensity) > 16'(w_rand[LFSR_W-1 -: 8]));
    end

    always_comb begin
        for (int i = 0; i < NUM_BUBBLES; i++) begin
            w_pool_d[i] = r_pool_q[i];
            if (w_mode == MODE_CLEAR) begin
                w_pool_d[i].active = 1'b0;
            end else if (w_run && r_pool_q[i].active) begin
                if (r_decay_tick_q) begin
                    if (|r_pool_q[i].R) w_pool_d[i].R = r_pool_q[i].R - 8'd1;
                    if (|r_pool_q[i].G) w_pool_d[i].G = r_pool_q[i].G - 8'd1;
                    if (|r_pool_q[i].B) w_pool_d[i].B = r_pool_q[i].B - 8'd1;
                    if (r_pool_q[i].age != 8'hFF) w_pool_d[i].age = r_pool_q[i].age + 8'd1;
                    if ((w_pool_d[i].R | w_pool_d[i].G | w_pool_d[i].B) == 8'h00) begin
                        w_pool_d[i].active = 1'b0;
                    end
                end
                if (r_rise_tick_q && (w_mode == MODE_RISE) && w_pool_d[i].active) begin
                    if (r_pool_q[i].y == 11'd0) w_pool_d[i].active = 1'b0;
                    else                        w_pool_d[i].y      = r_pool_q[i].y - 11'd1;
                end
            end
        end
        if (w_spawn) begin
            w_pool_d[w_slot] = w_new_bubble;
        end
    end

    always_comb begin
        w_active_cnt_d = '0;
        for (int i = 0; i < NUM_BUBBLES; i++) begin
            w_active_cnt_d = w_active_cnt_d + c_cnt_w'(r_pool_q[i].active);
        end
    end

    for (genvar g = 0; g < NUM_BUBBLES; g++) begin : g_slot
        logic signed [11:0] w_dx, w_dy;
        logic signed [23:0] w_dx_ext, w_dy_ext;
        logic [23:0]        w_dx2, w_dy2, w_rad2;
        logic [24:0]        w_dist;
        logic [11:0]        w_rad;
        assign w_dx       = $signed({1'b0, i_VGA_X}) - $signed({1'b0, r_pool_q[g].x});
        assign w_dy       = $signed({1'b0, i_VGA_Y}) - $signed({1'b0, r_pool_q[g].y});
        assign w_dx_ext   = {{12{w_dx[11]}}, w_dx};
        assign w_dy_ext   = {{12{w_dy[11]}}, w_dy};
        assign w_dx2      = w_dx_ext * w_dx_ext;
        assign w_dy2      = w_dy_ext * w_dy_ext;
        assign w_dist     = {1'b0, w_dx2} + {1'b0, w_dy2};
        assign w_rad      = {1'b0, r_pool_q[g].r} + {7'd0, i_radius_off};
        assign w_rad2     = {12'd0, w_rad} * {12'd0, w_rad};
        assign w_hit_d[g] = r_pool_q[g].active && (w_dist <= {1'b0, w_rad2});
        assign w_sr_d[g]  = r_pool_q[g].R >> r_pool_q[g].age[7:6];
        assign w_sg_d[g]  = r_pool_q[g].G >> r_pool_q[g].age[7:6];
        assign w_sb_d[g]  = r_pool_q[g].B >> r_pool_q[g].age[7:6];
    end

    always_comb begin
        w_out_r_d = 8'h00;
        w_out_g_d = 8'h00;
        w_out_b_d = 8'h00;
        for (int i = 0; i < NUM_BUBBLES; i++) begin
            if (r_hit_q[i]) begin
                w_out_r_d = add8(w_out_r_d, r_sr_q[i]);
                w_out_g_d = add8(w_out_g_d, r_sg_q[i]);
                w_out_b_d = add8(w_out_b_d, r_sb_q[i]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc_q        <= '0;
            r_spawn_tick_q <= 1'b0;
            r_decay_tick_q <= 1'b0;
            r_rise_tick_q  <= 1'b0;
            r_active_cnt_q <= '0;
            r_hit_q        <= '0;
            r_out_r_q      <= 8'h00;
            r_out_g_q      <= 8'h00;
            r_out_b_q      <= 8'h00;
            for (int i = 0; i < NUM_BUBBLES; i++) begin
                r_pool_q[i] <= '0;
                r_sr_q[i]   <= 8'h00;
                r_sg_q[i]   <= 8'h00;
                r_sb_q[i]   <= 8'h00;
            end
        end else begin
            r_cyc_q        <= w_cyc_d;
            r_spawn_tick_q <= w_spawn_tick_d;
            r_decay_tick_q <= w_decay_tick_d;
            r_rise_tick_q  <= w_rise_tick_d;
            r_active_cnt_q <= w_active_cnt_d;
            r_hit_q        <= w_hit_d;
            r_out_r_q      <= w_out_r_d;
            r_out_g_q      <= w_out_g_d;
            r_out_b_q      <= w_out_b_d;
            for (int i = 0; i < NUM_BUBBLES; i++) begin
                r_pool_q[i] <= w_pool_d[i];
                r_sr_q[i]   <= w_sr_d[i];
                r_sg_q[i]   <= w_sg_d[i];
                r_sb_q[i]   <= w_sb_d[i];
            end
        end
    end

    assign o_VGA_R      = r_out_r_q;
    assign o_VGA_G      = r_out_g_q;
    assign o_VGA_B      = r_out_b_q;
    assign o_active_cnt = r_active_cnt_q;

endmodule
`default_nettype wire

// File: doc/bubble_field_renderer.md
# bubble_field_renderer

Parametrised audio-reactive bubble layer for the VGA visualiser. It keeps a pool of NUM_BUBBLES circles, each with position, radius, colour, age and transparency. Bubbles are spawned from spectrum intensity into free slots. When the pool is full, the oldest bubble is replaced. The block owns its timers, fades and optionally drifts bubbles upward, and composites every bubble covering the current pixel through a 2-stage pipeline. It sits between the spectrum analyser (i_DATA) and the VGA output mux, beside the other renderers.

## Interface
Parameters:
- NUM_BUBBLES, 16: pool size (2..32)
- NUM_BANDS, 16: spectrum channels, multiple of 4
- DATA_W, 4: bits per band
- MIN_RADIUS, 45: base radius in pixels
- H_RES, 640 / V_RES, 480: active area
- SPAWN_LOG2, 21 / DECAY_LOG2, 19 / RISE_LOG2, 18: tick periods of 2^N cycles
- LFSR_W, 34: random generator width (≥ 24)

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_DATA  in  NUM_BANDS×DATA_W  spectrum magnitudes
- i_VGA_X, i_VGA_Y  in  11 each  pixel coordinate being requested
- i_radius_off  in  5  global radius boost
- i_mode  in  2  0 = static fade, 1 = rise, 2 = freeze (no spawn/decay/rise), 3 = clear
- o_VGA_R, o_VGA_G, o_VGA_B  out  8 each  composited colour
- o_active_cnt  out  $clog2(NUM_BUBBLES+1)  live bubbles

## Operation
- Free-running 32-bit cycle counter. The low N bits wrapping to 0 raise the spawn, decay or rise tick (one cycle each).
- Spawn tick, mode 0/1:
  - Intensity = sum of all bands (DATA_W+$clog2(NUM_BANDS) bits).
  - Spawn if intensity > rand[LFSR_W-1 -: 8].
  - Slot = lowest-index inactive slot. Otherwise the active slot with the largest age; ties go to the lowest index.
- New bubble fields:
  - x = rand[9:0]; if x ≥ H_RES, x −= 512.
  - y = rand[18:10]; if y ≥ V_RES, y −= 256.
  - Segment s = x / (H_RES/4).
  - r = MIN_RADIUS + (i_DATA[s·NUM_BANDS/4 + 1] << 2) + rand[23:19].
  - age = 0, alpha level = 0.
  - Colour uses ramp = ((x − s·H_RES/4)·255)/(H_RES/4), computed as a constant multiply-shift that is exact for the default values:
    - s0: (255, ramp, 0)
    - s1: (255−ramp, 255, 0)
    - s2: (0, 255, ramp)
    - s3: (0, 255−ramp, 255)
- Decay tick, mode 0/1, every active slot:
  - Each nonzero colour channel −1.
  - Age +1, saturating at 255.
  - Alpha level = age[7:6].
  - A slot whose colour reaches (0,0,0) goes inactive.
- Rise tick, mode 1: y −1 for each active slot. A slot with y = 0 goes inactive instead.
- Mode 2: pool state held. Pixel path still runs.
- Mode 3: all slots inactive on the next cycle; no spawns while held.
- Spawn and decay in the same cycle: decay applies to existing slots only. The spawned slot is written with fresh, undecayed values, and the spawn write wins for that slot.
- Pixel path:
  - Hit = (X−x)² + (Y−y)² ≤ (r + i_radius_off)², using signed 12-bit differences and 24-bit squares. No wrap at screen edges.
  - Output = per-channel saturating (at 255) sum over hits of colour >> alpha level.
- LFSR is a Galois register with a nonzero reset seed (1) and advances every cycle.

## Timing
- Reset: all slots inactive, counter = 0, outputs 0, o_active_cnt = 0, LFSR = 1. Reset applied mid-frame takes effect on the next edge, with no partial frame artifacts after it.
- Pixel latency is exactly 2 cycles:
  - Stage 1 registers the hit vector plus per-slot shifted colour.
  - Stage 2 registers the saturated sum.
  - The caller presents coordinates 2 pixels early.
- Pool updates land 1 cycle after the tick. o_active_cnt reflects the pool 1 cycle later.
- Pixel stage 1 samples the pool registers of the same cycle; no pool update is deferred to blanking.
- With i_mode = 3, o_active_cnt reaches 0 two cycles after i_mode changes.

## Structure
- Package bubble_pkg:
  - bubble_t struct {active, x[10:0], y[10:0], r[10:0], R, G, B, age}
  - mode_e enum
  - hue_ramp function
  - saturating add8 function
- Sub-module bubble_lfsr (parameter LFSR_W; taps for 34 bits: 34, 27, 2, 1).
- Slot allocator (priority encoder plus max-age search) stays inline.

## Test plan
- Reset then mode 0, all i_DATA = 15 (intensity 240), LFSR forced by a bench seed → first spawn at cycle 2^21. o_active_cnt = 1 at tick+2.
- Single bubble at (100,100), r = 45, colour (255,159,0), alpha 0, i_radius_off = 0 → pixel (145,100) gives (255,159,0) after 2 cycles. Pixel (146,100) gives (0,0,0).
- Two overlapping bubbles (255,0,0) and (255,255,0) at alpha 0 → overlap pixel = (255,255,0), saturated.
- Fill all NUM_BUBBLES slots, then spawn once → slot with max age replaced; o_active_cnt unchanged.
- Mode 1, bubble at y = 2 → inactive after the 3rd rise tick. Mode 3 → count 0 within 2 cycles.
- Spawn and decay coincident (force SPAWN_LOG2 = DECAY_LOG2) → new slot holds undecayed colour; others decremented by 1.
